rf_wb_arbiter: RTL

Shares the register file's single write port between the in-order pipeline W stage and NUM_LL long-latency units (divider, load-miss return, etc.). It also holds a per-register busy scoreboard so that issue logic stalls on operands still owed by a long-latency unit. It sits between the W stage, the long-latency units and the register file's write-back inputs (wb_en/rd/data). Grant is same-cycle, so the register file's internal write-through forwarding stays valid.

---
 rtl/rf_wb_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between the W stage and NUM_LL long-latency units, and tracks per-register busy state.
// Define RF_WB_STARVE_GUARD_EN to build the starvation counter that drives o_pipe_hold.
`timescale 1ns/1ps
module rf_wb_arbiter #(
    parameter int NUM_LL       = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_pipe_wb_en,
    input  logic [4:0]             i_pipe_rd,
    input  logic [31:0]            i_pipe_data,
    input  logic [NUM_LL-1:0]      i_ll_valid,
    input  logic [5*NUM_LL-1:0]    i_ll_rd,
    input  logic [32*NUM_LL-1:0]   i_ll_data,
    output logic [NUM_LL-1:0]      o_ll_ready,
    output logic                   o_wb_en,
    output logic [4:0]             o_wb_rd,
    output logic [31:0]            o_wb_data,
    input  logic                   i_issue_en,
    input  logic [4:0]             i_issue_rd,
    input  logic [4:0]             i_rs1_index,
    input  logic [4:0]             i_rs2_index,
    output logic                   o_rs1_busy,
    output logic                   o_rs2_busy,
    output logic                   o_rd_busy,
    output logic                   o_pipe_hold
);

    localparam int PW = (NUM_LL > 1) ? $clog2(NUM_LL) : 1;

    if (NUM_LL < 1 || NUM_LL > 8 || STARVE_LIMIT < 2 || STARVE_LIMIT > 15) begin : g_bad_params
        $error("rf_wb_arbiter: NUM_LL or STARVE_LIMIT out of range");
    end

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] grant_idx;
    logic          ll_found;
    logic          pipe_win;
    logic          ll_grant;
    logic [31:0]   busy;
    logic [31:0]   busy_next;

    assign pipe_win = !o_pipe_hold && i_pipe_wb_en;

    // Round-robin search begins one past the last granted unit.
    always_comb begin
        int cand;
        cand      = 0;
        ll_found  = 1'b0;
        grant_idx = rr_ptr;
        for (int i = 1; i <= NUM_LL; i++) begin
            cand = (int'(rr_ptr) + i) % NUM_LL;
            if (!ll_found && i_ll_valid[cand]) begin
                ll_found  = 1'b1;
                grant_idx = PW'(cand);
            end
        end
    end

    always_comb begin
        o_ll_ready = '0;
        o_wb_en    = 1'b0;
        o_wb_rd    = '0;
        o_wb_data  = '0;
        ll_grant   = 1'b0;
        if (!rst) begin
            if (pipe_win) begin
                o_wb_en   = 1'b1;
                o_wb_rd   = i_pipe_rd;
                o_wb_data = i_pipe_data;
            end else if (ll_found) begin
                ll_grant              = 1'b1;
                o_ll_ready[grant_idx] = 1'b1;
                o_wb_en               = 1'b1;
                o_wb_rd               = i_ll_rd[5*int'(grant_idx) +: 5];
                o_wb_data             = i_ll_data[32*int'(grant_idx) +: 32];
            end
        end
    end

    // A register whose owed write is being granted now reads not-busy; the RF forwards it.
    assign o_rs1_busy = !rst && busy[i_rs1_index] && !(ll_grant && o_wb_rd == i_rs1_index);
    assign o_rs2_busy = !rst && busy[i_rs2_index] && !(ll_grant && o_wb_rd == i_rs2_index);
    assign o_rd_busy  = !rst && busy[i_issue_rd]  && !(ll_grant && o_wb_rd == i_issue_rd);

    always_comb begin
        busy_next = busy;
        if (ll_grant) begin
            busy_next[o_wb_rd] = 1'b0;
        end
        if (i_issue_en && i_issue_rd != 5'd0) begin
            busy_next[i_issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= PW'(NUM_LL - 1);
        end else if (ll_grant) begin
            rr_ptr <= grant_idx;
        end
    end

`ifdef RF_WB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;
    logic [3:0] starve_cnt_next;
    logic       pipe_hold;

    // Counts consecutive pipeline wins over a waiting ll request.
    always_comb begin
        starve_cnt_next = starve_cnt;
        if (ll_grant || !(|i_ll_valid)) begin
            starve_cnt_next = '0;
        end else if (pipe_win) begin
            starve_cnt_next = starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
            pipe_hold  <= 1'b0;
        end else begin
            starve_cnt <= starve_cnt_next;
            pipe_hold  <= (starve_cnt_next == 4'(STARVE_LIMIT));
        end
    end

    assign o_pipe_hold = pipe_hold;
`else
    assign o_pipe_hold = 1'b0;
`endif

endmodule
